// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core's control decoder and a
// request/grant/valid data-memory bus. Aligns byte enables and store data to
// word lanes, extends load data, and stalls the core while an access is open.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access open; a new MemWE/MemLD is decoded combinationally
// REQ    | BUS_REQ high with latched fields, waiting for BUS_GNT
// WAIT   | request accepted, waiting for BUS_RVALID (data or store ack)
// DONE   | one-cycle result: RDATA/ERR valid, core advances on this edge
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemWE,
  input  logic        MemLD,
  input  logic [3:0]  byteEnable,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        STALL,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_GNT,
  input  logic        BUS_RVALID,
  input  logic [31:0] BUS_RDATA
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_inc;
  logic        w_timeout;
  logic        r_bus_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_zext;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_access;
  logic        w_size_ok;
  logic        w_misaligned;
  logic [1:0]  w_size;
  logic        w_err_nxt;
  logic        w_rsp_ok;
  logic [31:0] w_lane_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_unused;

  // Size only comes from byteEnable; the low FUNCT3 bits duplicate it.
  assign w_unused = ^FUNCT3[1:0];

  assign w_access  = MemWE | MemLD;
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_timeout = (w_cnt_inc == TIMEOUT_CNT);

  // Decode the unshifted size mask and alignment of the incoming access.
  always_comb begin
    w_size_ok    = 1'b1;
    w_size       = SZ_BYTE;
    w_misaligned = 1'b0;
    case (byteEnable)
      4'b0001: w_size = SZ_BYTE;
      4'b0011: begin
        w_size       = SZ_HALF;
        w_misaligned = ADDR[0];
      end
      4'b1111: begin
        w_size       = SZ_WORD;
        w_misaligned = (ADDR[1:0] != 2'b00);
      end
      default: w_size_ok = 1'b0;
    endcase
  end

  // Next-state logic; a response in WAIT wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_rsp_ok    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (!w_size_ok || w_misaligned) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else if (BUS_GNT) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (BUS_RVALID) begin
          w_state_nxt = S_DONE;
          w_rsp_ok    = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pick the addressed lane out of the response word and extend it.
  always_comb begin
    w_lane_shift = BUS_RDATA >> {r_lane, 3'b000};
    w_byte       = w_lane_shift[7:0];
    w_half       = r_lane[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];
    case (r_size)
      SZ_BYTE: w_ext = {{24{~r_zext & w_byte[7]}}, w_byte};
      SZ_HALF: w_ext = {{16{~r_zext & w_half[15]}}, w_half};
      default: w_ext = BUS_RDATA;
    endcase
  end

  // State, timeout counter, latched bus fields and registered results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_bus_req <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_be      <= 4'd0;
      r_wdata   <= 32'd0;
      r_lane    <= 2'd0;
      r_size    <= SZ_BYTE;
      r_zext    <= 1'b0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_req <= (w_state_nxt == S_REQ);
      r_err     <= w_err_nxt;
      r_rdata   <= (w_rsp_ok && !r_we) ? w_ext : 32'd0;
      if (r_state == S_IDLE && w_state_nxt == S_REQ) begin
        r_cnt   <= 16'd0;
        r_we    <= MemWE;
        r_addr  <= {ADDR[31:2], 2'b00};
        r_be    <= byteEnable << ADDR[1:0];
        r_wdata <= WDATA << {ADDR[1:0], 3'b000};
        r_lane  <= ADDR[1:0];
        r_size  <= w_size;
        r_zext  <= FUNCT3[2];
      end else if (r_state == S_REQ || r_state == S_WAIT) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign STALL     = ((r_state == S_IDLE) && w_access) || (r_state == S_REQ) || (r_state == S_WAIT);
  assign RDATA     = r_rdata;
  assign ERR       = r_err;
  assign BUS_REQ   = r_bus_req;
  assign BUS_WE    = r_we;
  assign BUS_ADDR  = r_addr;
  assign BUS_BE    = r_be;
  assign BUS_WDATA = r_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed vectors for riscv_lsu with hand-computed results.
module tb_riscv_lsu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemWE, MemLD;
  logic [3:0]  byteEnable;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR, WDATA;
  logic        STALL;
  logic [31:0] RDATA;
  logic        ERR;
  logic        BUS_REQ, BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [3:0]  BUS_BE;
  logic [31:0] BUS_WDATA;
  logic        BUS_GNT, BUS_RVALID;
  logic [31:0] BUS_RDATA;

  int n_checks = 0;
  int n_fail   = 0;

  int          res_stall, res_req, res_done_c;
  logic        res_done, res_err, res_we;
  logic [31:0] res_rdata, res_addr, res_wdata;
  logic [3:0]  res_be;

  riscv_lsu #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .MemWE(MemWE), .MemLD(MemLD),
    .byteEnable(byteEnable), .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA),
    .STALL(STALL), .RDATA(RDATA), .ERR(ERR),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE),
    .BUS_WDATA(BUS_WDATA), .BUS_GNT(BUS_GNT), .BUS_RVALID(BUS_RVALID),
    .BUS_RDATA(BUS_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one access and play the memory: grant after gnt_dly REQ cycles,
  // answer after rv_dly WAIT cycles. Results land in the res_* variables.
  task automatic do_access(input logic we, input logic ld, input logic [3:0] be,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gnt_dly,
                           input int rv_dly, input logic [31:0] rdata);
    int   n_req;
    int   n_wait;
    logic granted;
    n_req = 0; n_wait = 0; granted = 1'b0;
    res_stall = 0; res_req = 0; res_done_c = 0; res_done = 1'b0;
    res_err = 1'b0; res_we = 1'b0; res_rdata = 32'd0; res_addr = 32'd0;
    res_wdata = 32'd0; res_be = 4'd0;
    @(negedge CLK);
    MemWE = we; MemLD = ld; byteEnable = be; FUNCT3 = f3; ADDR = addr; WDATA = wdata;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c > 0 && !STALL) begin
        res_done = 1'b1; res_done_c = c; res_rdata = RDATA; res_err = ERR;
        MemWE = 1'b0; MemLD = 1'b0; BUS_GNT = 1'b0; BUS_RVALID = 1'b0;
        break;
      end
      if (STALL) res_stall++;
      if (BUS_REQ) begin
        res_req++;
        res_addr = BUS_ADDR; res_be = BUS_BE; res_wdata = BUS_WDATA; res_we = BUS_WE;
      end
      if (BUS_GNT) granted = 1'b1;
      BUS_GNT = 1'b0; BUS_RVALID = 1'b0;
      if (BUS_REQ) begin
        if (n_req == gnt_dly) BUS_GNT = 1'b1;
        n_req++;
      end else if (granted) begin
        if (n_wait == rv_dly) begin
          BUS_RVALID = 1'b1;
          BUS_RDATA  = rdata;
        end
        n_wait++;
      end
      @(negedge CLK);
    end
    check_val("done_seen", {31'd0, res_done}, 32'd1);
  endtask

  task automatic check_err_path(input string tag);
    check_val({tag, "_req"},   res_req,    32'd0);
    check_val({tag, "_stall"}, res_stall,  32'd1);
    check_val({tag, "_donec"}, res_done_c, 32'd1);
    check_val({tag, "_err"},   {31'd0, res_err}, 32'd1);
    check_val({tag, "_rdata"}, res_rdata,  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; MemWE = 1'b0; MemLD = 1'b0; byteEnable = 4'd0; FUNCT3 = 3'd0;
    ADDR = 32'd0; WDATA = 32'd0; BUS_GNT = 1'b0; BUS_RVALID = 1'b0; BUS_RDATA = 32'd0;
    repeat (3) @(negedge CLK);
    #1;
    check_val("rst_stall",   {31'd0, STALL},   32'd0);
    check_val("rst_busreq",  {31'd0, BUS_REQ}, 32'd0);
    check_val("rst_rdata",   RDATA,            32'd0);
    check_val("rst_err",     {31'd0, ERR},     32'd0);
    check_val("rst_busaddr", BUS_ADDR,         32'd0);
    RST = 1'b0;

    // LB at lane 3, minimum latency
    do_access(1'b0, 1'b1, 4'b0001, 3'b000, 32'h0000_1003, 32'd0, 0, 0, 32'h80FF_1234);
    check_val("lb_addr",  res_addr,  32'h0000_1000);
    check_val("lb_be",    {28'd0, res_be}, 32'h8);
    check_val("lb_we",    {31'd0, res_we}, 32'd0);
    check_val("lb_rdata", res_rdata, 32'hFFFF_FF80);
    check_val("lb_err",   {31'd0, res_err}, 32'd0);
    check_val("lb_stall", res_stall, 32'd3);
    check_val("lb_donec", res_done_c, 32'd3);
    check_val("lb_req",   res_req,   32'd1);
    @(negedge CLK); #1;
    check_val("idle_rdata", RDATA, 32'd0);
    check_val("idle_err",   {31'd0, ERR}, 32'd0);

    do_access(1'b0, 1'b1, 4'b0011, 3'b101, 32'h0000_2002, 32'd0, 0, 0, 32'h8001_0000);
    check_val("lhu_be",    {28'd0, res_be}, 32'hC);
    check_val("lhu_rdata", res_rdata, 32'h0000_8001);

    do_access(1'b0, 1'b1, 4'b0011, 3'b001, 32'h0000_2002, 32'd0, 0, 0, 32'h8001_0000);
    check_val("lh_rdata", res_rdata, 32'hFFFF_8001);

    do_access(1'b0, 1'b1, 4'b0001, 3'b100, 32'h0000_3001, 32'd0, 0, 0, 32'h0000_F100);
    check_val("lbu_be",    {28'd0, res_be}, 32'h2);
    check_val("lbu_rdata", res_rdata, 32'h0000_00F1);

    do_access(1'b0, 1'b1, 4'b1111, 3'b010, 32'h0000_0010, 32'd0, 0, 2, 32'h1234_5678);
    check_val("lw_rdata", res_rdata, 32'h1234_5678);
    check_val("lw_stall", res_stall, 32'd5);
    check_val("lw_be",    {28'd0, res_be}, 32'hF);

    // SB with grant held off 4 cycles
    do_access(1'b1, 1'b0, 4'b0001, 3'b000, 32'h0000_0041, 32'h0000_00AB, 4, 0, 32'hFFFF_FFFF);
    check_val("sb_req",   res_req,   32'd5);
    check_val("sb_we",    {31'd0, res_we}, 32'd1);
    check_val("sb_be",    {28'd0, res_be}, 32'h2);
    check_val("sb_wdata", res_wdata, 32'h0000_AB00);
    check_val("sb_addr",  res_addr,  32'h0000_0040);
    check_val("sb_rdata", res_rdata, 32'd0);
    check_val("sb_donec", res_done_c, 32'd7);

    do_access(1'b1, 1'b0, 4'b1111, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'hFFFF_FFFF);
    check_val("sw_wdata", res_wdata, 32'hDEAD_BEEF);
    check_val("sw_be",    {28'd0, res_be}, 32'hF);
    check_val("sw_rdata", res_rdata, 32'd0);

    do_access(1'b1, 1'b0, 4'b0011, 3'b001, 32'h0000_0202, 32'h0000_1234, 1, 1, 32'd0);
    check_val("sh_be",    {28'd0, res_be}, 32'hC);
    check_val("sh_wdata", res_wdata, 32'h1234_0000);

    // both controls high: store wins
    do_access(1'b1, 1'b1, 4'b1111, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 0, 0, 32'hFFFF_FFFF);
    check_val("both_we",    {31'd0, res_we}, 32'd1);
    check_val("both_rdata", res_rdata, 32'd0);

    do_access(1'b1, 1'b0, 4'b1111, 3'b010, 32'h0000_0006, 32'h1, 0, 0, 32'd0);
    check_err_path("sw_mis");
    do_access(1'b0, 1'b1, 4'b0011, 3'b001, 32'h0000_0001, 32'd0, 0, 0, 32'd0);
    check_err_path("lh_mis");
    do_access(1'b0, 1'b1, 4'b0000, 3'b010, 32'h0000_0400, 32'd0, 0, 0, 32'd0);
    check_err_path("be_inv");

    // timeout: no grant ever
    do_access(1'b0, 1'b1, 4'b1111, 3'b010, 32'h0000_0500, 32'd0, 99, 0, 32'd0);
    check_val("to_req",   res_req,   32'd8);
    check_val("to_err",   {31'd0, res_err}, 32'd1);
    check_val("to_rdata", res_rdata, 32'd0);
    check_val("to_donec", res_done_c, 32'd9);
    @(negedge CLK); #1;
    BUS_RVALID = 1'b1; BUS_RDATA = 32'hFFFF_FFFF;
    @(negedge CLK); #1;
    BUS_RVALID = 1'b0;
    check_val("late_stall", {31'd0, STALL}, 32'd0);
    check_val("late_err",   {31'd0, ERR},   32'd0);
    check_val("late_rdata", RDATA,          32'd0);
    do_access(1'b0, 1'b1, 4'b1111, 3'b010, 32'h0000_0504, 32'd0, 0, 0, 32'hA5A5_A5A5);
    check_val("after_to_rdata", res_rdata, 32'hA5A5_A5A5);
    check_val("after_to_err",   {31'd0, res_err}, 32'd0);

    // reset while in WAIT
    @(negedge CLK);
    MemLD = 1'b1; byteEnable = 4'b1111; FUNCT3 = 3'b010; ADDR = 32'h0000_0080; WDATA = 32'h55;
    @(negedge CLK); #1;
    check_val("rw_busreq", {31'd0, BUS_REQ}, 32'd1);
    BUS_GNT = 1'b1;
    @(negedge CLK); #1;
    BUS_GNT = 1'b0;
    check_val("rw_wait_stall", {31'd0, STALL}, 32'd1);
    RST = 1'b1; MemLD = 1'b0;
    @(negedge CLK); #1;
    check_val("rw_busreq0", {31'd0, BUS_REQ}, 32'd0);
    check_val("rw_buswe0",  {31'd0, BUS_WE},  32'd0);
    check_val("rw_addr0",   BUS_ADDR,         32'd0);
    check_val("rw_be0",     {28'd0, BUS_BE},  32'd0);
    check_val("rw_wdata0",  BUS_WDATA,        32'd0);
    check_val("rw_rdata0",  RDATA,            32'd0);
    check_val("rw_err0",    {31'd0, ERR},     32'd0);
    check_val("rw_stall0",  {31'd0, STALL},   32'd0);
    RST = 1'b0; BUS_RVALID = 1'b1; BUS_RDATA = 32'h1234_5678;
    @(negedge CLK); #1;
    BUS_RVALID = 1'b0;
    check_val("rw_post_rdata", RDATA, 32'd0);
    check_val("rw_post_stall", {31'd0, STALL}, 32'd0);
    @(negedge CLK); #1;
    check_val("rw_post2_rdata", RDATA, 32'd0);
    check_val("rw_post2_err",   {31'd0, ERR}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit that consumes the memory control signals produced by the core's control decoder (MemWE, MemLD, byteEnable) and executes them against a request/grant/valid data-memory bus. It sits between the datapath's ALU result / rs2 path and data memory. It aligns byte enables and store data to word lanes, and sign- or zero-extends load data. It stalls the core until each access completes, errors or times out.

## Interface

- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before an access is aborted (1..65535).
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- MemWE  in  1  store request from control decoder.
- MemLD  in  1  load request from control decoder.
- byteEnable  in  4  unshifted size mask: 0001 byte, 0011 half, 1111 word, 0000 invalid.
- FUNCT3  in  3  INST[14:12]; bit 2 = 1 selects zero-extension for loads.
- ADDR  in  32  effective address (ALU result).
- WDATA  in  32  store data (rs2), right-justified.
- STALL  out  1  high while an access is outstanding; core freezes PC and pipeline inputs.
- RDATA  out  32  extended load result; valid in DONE only.
- ERR  out  1  one-cycle pulse in DONE for misaligned, invalid-size or timed-out access.
- BUS_REQ  out  1  request valid.
- BUS_WE  out  1  1 = write.
- BUS_ADDR  out  32  {ADDR[31:2], 2'b00}.
- BUS_BE  out  4  byteEnable << ADDR[1:0].
- BUS_WDATA  out  32  WDATA << (8*ADDR[1:0]).
- BUS_GNT  in  1  request accepted this cycle.
- BUS_RVALID  in  1  response (load data or store ack) valid.
- BUS_RDATA  in  32  word-aligned load data.

## Operation

- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: access = MemWE | MemLD; MemWE has priority if both are high (treated as a store). On access:
  - If it is valid and aligned, latch BUS_WE/ADDR/BE/WDATA, FUNCT3 and ADDR[1:0], then go to REQ.
  - If it is invalid (byteEnable = 0000) or misaligned (half with ADDR[0]=1, word with ADDR[1:0]≠0), go to DONE with the error flag set; no bus activity.
- REQ: BUS_REQ=1 with latched fields held stable. On BUS_GNT go to WAIT. BUS_RVALID is ignored in REQ.
- WAIT: BUS_REQ=0. On BUS_RVALID, capture BUS_RDATA (loads), clear the error flag and go to DONE.
- DONE: unconditionally return to IDLE next cycle.
- Timeout: counter cleared on IDLE→REQ, incremented each REQ/WAIT cycle. At count == TIMEOUT go to DONE with ERR, RDATA=0, BUS_REQ dropped. A late BUS_RVALID (in IDLE/DONE) is ignored.
- Load extraction: lane = latched ADDR[1:0].
  - Byte: BUS_RDATA[8*lane+7 : 8*lane].
  - Half: BUS_RDATA[16*ADDR[1]+15 : 16*ADDR[1]].
  - Word: whole word.
  - Sign-extend when FUNCT3[2]=0, otherwise zero-extend. Store results present RDATA=0.
- Core contract: ADDR/WDATA/controls are held stable while STALL=1. The core advances on the DONE cycle edge; the next instruction is sampled in IDLE the cycle after DONE.

## Timing

- Reset (any state, including mid-access): state IDLE, BUS_REQ=0, BUS_WE=0, BUS_ADDR=0, BUS_BE=0, BUS_WDATA=0, RDATA=0, ERR=0, counter=0. An outstanding bus response is abandoned.
- STALL = (IDLE & access) | REQ | WAIT, driven combinationally in IDLE. STALL=0 in DONE.
- BUS_REQ is registered: first asserted the cycle after the access appears.
- Minimum latency with BUS_GNT in the first REQ cycle and BUS_RVALID the next cycle: STALL high 3 cycles (IDLE, REQ, WAIT), RDATA valid in cycle 4 (DONE).
- Error path without bus access: STALL high 1 cycle; ERR and DONE in cycle 2.
- RDATA and ERR are registered; they hold their values only during DONE and return to 0 in IDLE.

## Test plan

- LB, ADDR=0x1003, BUS_RDATA=0x80FF_1234 with GNT in the first REQ cycle and RVALID one cycle later -> BUS_ADDR=0x1000, BUS_BE=1000, RDATA=0xFFFF_FF80, STALL high exactly 3 cycles, ERR=0.
- LHU, ADDR=0x2002, BUS_RDATA=0x8001_0000 -> BUS_BE=1100, RDATA=0x0000_8001.
- SB, ADDR=0x41, WDATA=0x0000_00AB, GNT delayed 4 cycles -> BUS_REQ held 5 cycles, BUS_WE=1, BUS_BE=0010, BUS_WDATA=0x0000_AB00, DONE after RVALID ack.
- SW, ADDR=0x6 -> no BUS_REQ, ERR pulse in cycle 2, STALL high 1 cycle. Repeat with LH at ADDR=0x1 and with byteEnable=0000: same result.
- TIMEOUT=8, LW with no GNT -> BUS_REQ drops after 8 cycles, ERR=1, RDATA=0; a later RVALID pulse is ignored and the next LW completes normally.
- RST asserted in WAIT -> next cycle all outputs 0 and state IDLE; a subsequent RVALID does not produce DONE.
